apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Converts a simple valid/ready command interface into APB3 transfers for one slave (e.g. the APB RAM).
//  Sits directly upstream of the slave: drives psel/penable/pwrite/paddr/pwdata and samples prdata/pready/pslverr.
//  Returns one response per command, with a watchdog that aborts transfers whose slave never asserts pready.
// PARAMETERS
//  ADDR_W   32  width of cmd_addr / paddr
//  DATA_W   32  width of write and read data
//  TIMEOUT  16  max ACCESS-phase cycles without pready before abort (>=2)
// PORTS
//  pclk         in   1       clock; everything is on its rising edge
//  preset       in   1       synchronous reset, active-high
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       bridge accepts a command this cycle
//  cmd_write    in   1       1 = write, 0 = read
//  cmd_addr     in   ADDR_W  target address
//  cmd_wdata    in   DATA_W  write data (ignored for reads)
//  rsp_valid    out  1       one-cycle response pulse; no backpressure
//  rsp_rdata    out  DATA_W  read data; 0 for writes and aborts
//  rsp_slverr   out  1       slave error or timeout
//  rsp_timeout  out  1       transfer aborted by the watchdog
//  psel         out  1       APB select
//  penable      out  1       APB enable (ACCESS phase)
//  pwrite       out  1       APB direction
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB ready
//  pslverr      in   1       APB error, valid only with pready
// BEHAVIOUR
//  - All outputs are registered. On reset every output is 0 and state is IDLE; cmd_ready rises the cycle after reset drops.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch write/addr/wdata and go to SETUP.
//  - SETUP (exactly 1 cycle): psel=1, penable=0, pwrite/paddr/pwdata = latched values, cmd_ready=0. Go to ACCESS.
//  - ACCESS: psel=1, penable=1, address/data/direction held stable.
//    - Each cycle, pready is sampled together with the watchdog count wd (0 on entry, +1 per cycle without pready).
//    - pready=1: psel and penable drop next cycle and rsp_valid pulses that same cycle.
//      - rsp_rdata = prdata for reads, 0 for writes.
//      - rsp_slverr = pslverr; rsp_timeout = 0.
//      - Go to IDLE.
//    - pready=0 and wd==TIMEOUT-1: abort. psel and penable drop; rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. Go to IDLE.
//  - Latency: cmd accepted at edge N; SETUP in N+1; ACCESS from N+2.
//    With a zero-wait slave sampled at N+2, rsp_valid is in N+3 and the next command can be accepted at N+4.
//    The APB RAM asserts pready one cycle into ACCESS, so expect rsp_valid at N+4.
//  - pready and pslverr are ignored outside ACCESS. pslverr is ignored unless pready=1.
//  - rsp_* hold their last value when rsp_valid=0. paddr/pwdata/pwrite hold their last value in IDLE.
//  - A command offered while cmd_ready=0 is not consumed; the requester holds it.
//  - Reset mid-transfer: next edge forces IDLE and all outputs to 0; no response is produced for the aborted command.
//  - wd width is $clog2(TIMEOUT+1); it saturates and never wraps.
// STRUCTURE
//  - Shared package apb_pkg holds:
//    - typedef enum {IDLE, SETUP, ACCESS} apb_mstate_e
//    - default ADDR_W/DATA_W localparams
//    - typedef struct apb_cmd_t {write, addr, wdata}
//  - One natural sub-module, apb_wdog_cnt: clear/enable/expire counter parameterised by TIMEOUT.
//  - FSM, command latch and response registers stay in the top.
// TESTING (bench pairs this block with the APB RAM slave unless stated)
//  1. Write 0xDEADBEEF to addr 5, then read addr 5.
//     -> write rsp slverr=0, rdata=0; read rsp rdata=0xDEADBEEF, slverr=0, timeout=0.
//  2. Read addr 40 (out of range). -> rsp_slverr=1, rsp_timeout=0.
//  3. pready tied 0, TIMEOUT=16, write addr 3.
//     -> psel stays high for 1 SETUP + 16 ACCESS cycles; then rsp_valid=1 with slverr=1, timeout=1.
//  4. cmd_valid held high with 4 writes queued (addr 0..3, data 0x10..0x13), then reads of addr 0..3.
//     -> each handshake occurs only in IDLE; reads return 0x10..0x13 in order; no command dropped or duplicated.
//  5. Assert preset in the 2nd ACCESS cycle of a stalled transfer (stub slave).
//     -> next cycle psel=penable=rsp_valid=0, state IDLE; a following read completes normally.
//  6. Check psel/penable sequence and stable paddr/pwdata/pwrite for every transfer.
//     -> SETUP always exactly one cycle; penable never high without psel.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and defaults for the APB master bridge
package apb_pkg;

   localparam int APB_ADDR_W  = 32;
   localparam int APB_DATA_W  = 32;
   localparam int APB_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_mstate_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_wdog_cnt.sv
// rtl/apb_wdog_cnt.sv - saturating ACCESS-phase watchdog counter
module apb_wdog_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int                CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  MAX   = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at TIMEOUT so a stuck enable can never wrap back below LAST.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command to APB3 master bridge with watchdog
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_mstate_e       state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_slverr_q, rsp_slverr_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              wd_clr, wd_en, wd_expire;

   apb_wdog_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk_i    (pclk),
      .rst_i    (preset),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expire_o (wd_expire)
   );

   // Outputs are computed for the next state so every port comes straight from a flop.
   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = 1'b0;
      psel_d        = 1'b0;
      penable_d     = 1'b0;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
      rsp_timeout_d = rsp_timeout_q;
      wd_clr        = 1'b0;
      wd_en         = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            psel_d    = 1'b1;
            penable_d = 1'b1;
            wd_clr    = 1'b1;
         end
         ACCESS: begin
            if (pready) begin
               state_d       = IDLE;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_slverr_d  = pslverr;
               rsp_timeout_d = 1'b0;
            end else if (wd_expire) begin
               state_d       = IDLE;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               psel_d    = 1'b1;
               penable_d = 1'b1;
               wd_en     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_slverr  = rsp_slverr_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a behavioural APB RAM slave
module tb_apb_master_bridge;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 16;
   localparam int DEPTH = 32;

   logic          pclk = 1'b0;
   logic          preset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_slverr, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic          pready, pslverr;

   apb_master_bridge #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .pclk        (pclk),
      .preset      (preset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          slverr;
      logic          timeout;
   } rsp_t;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            acc;
   } xfer_t;

   rsp_t          rsp_q[$];
   xfer_t         xfer_q[$];
   logic [DW-1:0] ref_mem[DEPTH];
   logic [DW-1:0] slv_mem[DEPTH];
   int            checks = 0;
   int            passes = 0;
   int            cur_wait = 1;
   bit            stall = 1'b0;
   int            acc_n = 0;
   bit            proto_bad = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // APB RAM slave: pready after cur_wait ACCESS cycles, error beyond DEPTH, noise outside ACCESS.
   always @(posedge pclk) begin
      #1;
      if (psel && penable) begin
         if (!stall && acc_n >= cur_wait) begin
            pready = 1'b1;
            if (paddr < DEPTH) begin
               pslverr = 1'b0;
               if (pwrite) begin
                  slv_mem[paddr[4:0]] = pwdata;
                  prdata = $urandom;
               end else begin
                  prdata = slv_mem[paddr[4:0]];
               end
            end else begin
               pslverr = 1'b1;
               prdata  = '0;
            end
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end
         acc_n++;
      end else begin
         acc_n   = 0;
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
         prdata  = $urandom;
      end
   end

   // Monitor: APB phase checks per transfer plus response scoreboard.
   bit            in_xfer = 1'b0;
   bit            bad = 1'b0;
   int            setup_n = 0;
   int            acc_cnt = 0;
   xfer_t         cur_x;
   logic [AW-1:0] snap_a;
   logic [DW-1:0] snap_d;
   logic          snap_w;

   always @(negedge pclk) begin
      if (preset) begin
         in_xfer = 1'b0;
      end else begin
         if (penable && !psel) proto_bad = 1'b1;
         if (psel) begin
            if (!in_xfer) begin
               in_xfer = 1'b1;
               setup_n = 0;
               acc_cnt = 0;
               bad     = 1'b0;
               snap_a  = paddr;
               snap_d  = pwdata;
               snap_w  = pwrite;
               cur_x.acc = -1;
               if (xfer_q.size() == 0) begin
                  check("unexpected_xfer", 1, 0);
               end else begin
                  cur_x = xfer_q.pop_front();
                  check("apb_addr", paddr, cur_x.addr);
                  check("apb_write", pwrite, cur_x.write);
                  if (cur_x.write) check("apb_wdata", pwdata, cur_x.wdata);
               end
            end
            if (!penable) setup_n++;
            else acc_cnt++;
            if (paddr !== snap_a || pwdata !== snap_d || pwrite !== snap_w) bad = 1'b1;
         end else if (in_xfer) begin
            in_xfer = 1'b0;
            check("setup_len", setup_n, 1);
            check("access_len", acc_cnt, cur_x.acc);
            check("apb_stable", bad, 0);
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               rsp_t e;
               e = rsp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_slverr", rsp_slverr, e.slverr);
               check("rsp_timeout", rsp_timeout, e.timeout);
            end
         end
      end
   end

   // Reference model runs at issue time; commands complete strictly in order.
   task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rsp_t  r;
      xfer_t x;
      bit    rdy, idle;
      int    n;
      x.write = w;
      x.addr  = a;
      x.wdata = d;
      if (stall) begin
         r.rdata = '0; r.slverr = 1'b1; r.timeout = 1'b1;
         x.acc = TO;
      end else begin
         x.acc     = cur_wait + 1;
         r.timeout = 1'b0;
         r.slverr  = (a >= DEPTH);
         r.rdata   = '0;
         if (a < DEPTH) begin
            if (w) ref_mem[a] = d;
            else   r.rdata = ref_mem[a];
         end
      end
      rsp_q.push_back(r);
      xfer_q.push_back(x);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      n = 0;
      do begin
         rdy  = cmd_ready;
         idle = !psel;
         @(posedge pclk); #1;
         n++;
      end while (!rdy && n < 200);
      if (!rdy) check("handshake_wait", 0, 1);
      else      check("handshake_in_idle", idle, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (rsp_q.size() != 0 && n < 100) begin
         @(posedge pclk); #1;
         n++;
      end
      if (rsp_q.size() != 0) check("rsp_wait_expired", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      preset    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i] = '0;
         slv_mem[i] = '0;
      end
      repeat (3) @(posedge pclk);
      #1;
      check("reset_outputs", |{cmd_ready, psel, penable, pwrite, paddr, pwdata,
                               rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, 0);
      preset = 1'b0;
      check("ready_low_at_release", cmd_ready, 0);
      @(posedge pclk); #1;
      check("ready_after_reset", cmd_ready, 1);

      cur_wait = 1;
      issue(1'b1, 32'd5, 32'hDEADBEEF); cmd_valid = 1'b0; wait_done();
      issue(1'b0, 32'd5, $urandom);     cmd_valid = 1'b0; wait_done();

      issue(1'b0, 32'd40, '0); cmd_valid = 1'b0; wait_done();

      stall = 1'b1;
      issue(1'b1, 32'd3, 32'h0000_1234); cmd_valid = 1'b0; wait_done();
      stall = 1'b0;

      for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), DW'(32'h10 + i));
      for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), $urandom);
      cmd_valid = 1'b0;
      wait_done();

      stall = 1'b1;
      issue(1'b0, 32'd7, '0);
      cmd_valid = 1'b0;
      begin
         int n = 0;
         while (!(psel && penable) && n < 20) begin
            @(posedge pclk); #1;
            n++;
         end
         check("reach_access", psel && penable, 1);
      end
      @(posedge pclk); #1;
      preset = 1'b1;
      rsp_q.delete();
      xfer_q.delete();
      @(posedge pclk); #1;
      check("mid_reset_outputs", {psel, penable, rsp_valid, cmd_ready}, 0);
      preset = 1'b0;
      stall  = 1'b0;
      issue(1'b0, 32'd5, '0); cmd_valid = 1'b0; wait_done();

      for (int k = 0; k < 60; k++) begin
         cur_wait = $urandom_range(0, 3);
         stall    = ($urandom_range(0, 9) == 0);
         issue(1'($urandom), AW'($urandom_range(0, 39)), $urandom);
         cmd_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge pclk); #1;
         end
         wait_done();
      end
      stall = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      check("penable_without_psel", proto_bad, 0);
      check("queues_drained", rsp_q.size() + xfer_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
